demuxs_pipe: RTL and testbench

- 1-to-4 registered demultiplexer. It is the distribution-side counterpart of the 4-to-1 operand select used in the datapath.
- Steers one N-bit input stream to one of four output lanes (A/B/C/D) using the same S1/S2 select encoding.
- Each lane has a one-entry output register with a valid/ready handshake and a delivered-beat counter.
- Sits between a producing pipeline stage and four independent consumers, for example parallel butterfly or transform units.

---
 rtl/fptd_mux_pkg.sv | 20 ++
 rtl/demux_lane_stage.sv | 62 ++++++
 rtl/demuxs_pipe.sv | 82 ++++++++
 tb/tb_demuxs_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fptd_mux_pkg.sv
// Shared lane-select definitions for the 4-to-1 operand select and the
// 1-to-4 distribution demux. Both use the same {S2,S1} encoding.
package fptd_mux_pkg;

    localparam int NUM_LANES = 4;

    // S1 picks within a pair, S2 picks the pair.
    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_sel_t;

    // Map the raw select pins onto a lane.
    function automatic lane_sel_t decode_lane(input logic s2, input logic s1);
        return lane_sel_t'({s2, s1});
    endfunction

endpackage

// File: rtl/demux_lane_stage.sv
// One output lane of the demux: a single-entry register with a valid/ready
// handshake and a free-running count of delivered beats.
module demux_lane_stage
    import fptd_mux_pkg::*;
#(
    parameter int N     = 76,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [N-1:0]     din,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt,
    output logic             can_accept
);

    logic [N-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    // Next-state: drain on handshake, then a load (if any) overrides the drain.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        fire    = valid_q & out_ready;
        if (fire) begin
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b0;
        end
        if (load) begin
            data_d  = din;
            valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the data register is cleared on reset because consumers may observe out_data; wide buffers that nobody reads before a write would normally be left unreset.
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign cnt        = cnt_q;
    assign can_accept = ~valid_q | out_ready;

endmodule

// File: rtl/demuxs_pipe.sv
// 1-to-4 registered demultiplexer: steers one input stream onto lanes A..D
// by {S2,S1}. in_ready depends combinationally on the selected lane's ready.
module demuxs_pipe
    import fptd_mux_pkg::*;
#(
    parameter int N     = 76,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S1,
    input  logic             S2,
    output logic [N-1:0]     out_a_data,
    output logic [N-1:0]     out_b_data,
    output logic [N-1:0]     out_c_data,
    output logic [N-1:0]     out_d_data,
    output logic             out_a_valid,
    output logic             out_b_valid,
    output logic             out_c_valid,
    output logic             out_d_valid,
    input  logic             out_a_ready,
    input  logic             out_b_ready,
    input  logic             out_c_ready,
    input  logic             out_d_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    lane_sel_t              sel;
    logic [NUM_LANES-1:0]   lane_ready;
    logic [NUM_LANES-1:0]   lane_valid;
    logic [NUM_LANES-1:0]   lane_can_accept;
    logic [NUM_LANES-1:0]   lane_load;
    logic [N-1:0]           lane_data [NUM_LANES];
    logic [CNT_W-1:0]       lane_cnt  [NUM_LANES];

    assign sel        = decode_lane(S2, S1);
    assign lane_ready = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};

    // Only the addressed lane gates in_ready and receives the load strobe.
    always_comb begin
        lane_load      = '0;
        in_ready       = rst_n & lane_can_accept[sel];
        lane_load[sel] = in_valid & in_ready;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane_stage #(
            .N     (N),
            .CNT_W (CNT_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (lane_load[i]),
            .din        (in_data),
            .out_ready  (lane_ready[i]),
            .out_data   (lane_data[i]),
            .out_valid  (lane_valid[i]),
            .cnt        (lane_cnt[i]),
            .can_accept (lane_can_accept[i])
        );
    end

    assign out_a_data  = lane_data[LANE_A];
    assign out_b_data  = lane_data[LANE_B];
    assign out_c_data  = lane_data[LANE_C];
    assign out_d_data  = lane_data[LANE_D];
    assign out_a_valid = lane_valid[LANE_A];
    assign out_b_valid = lane_valid[LANE_B];
    assign out_c_valid = lane_valid[LANE_C];
    assign out_d_valid = lane_valid[LANE_D];
    assign cnt_a       = lane_cnt[LANE_A];
    assign cnt_b       = lane_cnt[LANE_B];
    assign cnt_c       = lane_cnt[LANE_C];
    assign cnt_d       = lane_cnt[LANE_D];

endmodule

// File: tb/tb_demuxs_pipe.sv
// Self-checking bench for demuxs_pipe: per-lane scoreboard queues filled on
// accept and drained on delivery, plus directed phases for reset, routing,
// back-pressure, streaming, counter wrap and reset mid-flight.
module tb_demuxs_pipe;

    localparam int N     = 76;
    localparam int CNT_W = 16;
    localparam int WN    = 8;
    localparam int WC    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic [N-1:0]     in_data;
    logic             in_valid, in_ready, S1, S2;
    logic [N-1:0]     od   [4];
    logic             ov   [4];
    logic             ordy [4];
    logic [CNT_W-1:0] oc   [4];

    // Narrow-counter DUT for the wrap test
    logic [WN-1:0]    w_data;
    logic             w_valid, w_ready, w_s1, w_s2;
    logic [WN-1:0]    w_od   [4];
    logic             w_ov   [4];
    logic             w_ordy [4];
    logic [WC-1:0]    w_oc   [4];

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard
    logic [N-1:0]     sb_q [4][$];
    logic [CNT_W-1:0] exp_cnt [4];

    demuxs_pipe #(.N(N), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .S1(S1), .S2(S2),
        .out_a_data(od[0]), .out_b_data(od[1]), .out_c_data(od[2]), .out_d_data(od[3]),
        .out_a_valid(ov[0]), .out_b_valid(ov[1]), .out_c_valid(ov[2]), .out_d_valid(ov[3]),
        .out_a_ready(ordy[0]), .out_b_ready(ordy[1]), .out_c_ready(ordy[2]), .out_d_ready(ordy[3]),
        .cnt_a(oc[0]), .cnt_b(oc[1]), .cnt_c(oc[2]), .cnt_d(oc[3])
    );

    demuxs_pipe #(.N(WN), .CNT_W(WC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_data(w_data), .in_valid(w_valid), .in_ready(w_ready),
        .S1(w_s1), .S2(w_s2),
        .out_a_data(w_od[0]), .out_b_data(w_od[1]), .out_c_data(w_od[2]), .out_d_data(w_od[3]),
        .out_a_valid(w_ov[0]), .out_b_valid(w_ov[1]), .out_c_valid(w_ov[2]), .out_d_valid(w_ov[3]),
        .out_a_ready(w_ordy[0]), .out_b_ready(w_ordy[1]), .out_c_ready(w_ordy[2]), .out_d_ready(w_ordy[3]),
        .cnt_a(w_oc[0]), .cnt_b(w_oc[1]), .cnt_c(w_oc[2]), .cnt_d(w_oc[3])
    );

    task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sample mid-cycle, predict the coming edge.
    always @(negedge clk) begin
        int  sel;
        logic exp_rdy;
        if (in_valid) begin
            assert (!$isunknown({S2, S1})) else $error("select is X while in_valid=1");
        end
        sel = int'({S2, S1});
        for (int l = 0; l < 4; l++) begin
            check("lane_valid", N'(ov[l]), N'(sb_q[l].size() != 0));
            if (sb_q[l].size() != 0) check("lane_data", od[l], sb_q[l][0]);
            check("lane_cnt", N'(oc[l]), N'(exp_cnt[l]));
        end
        exp_rdy = rst_n && (sb_q[sel].size() == 0 || ordy[sel]);
        check("in_ready", N'(in_ready), N'(exp_rdy));
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                sb_q[l].delete();
                exp_cnt[l] = '0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (sb_q[l].size() != 0 && ordy[l]) begin
                    void'(sb_q[l].pop_front());
                    exp_cnt[l] = exp_cnt[l] + 1'b1;
                end
            end
            if (in_valid && exp_rdy) sb_q[sel].push_back(in_data);
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int lane, input logic [N-1:0] d, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        {S2, S1} = 2'(lane);
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) check("send_timeout", N'(0), N'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
    endtask

    initial begin
        int w;
        logic [WC-1:0] prev, cur;
        logic wrapped;

        for (int l = 0; l < 4; l++) begin
            exp_cnt[l] = '0;
            ordy[l]    = 1'b1;
            w_ordy[l]  = 1'b1;
        end
        in_data = '0; in_valid = 1'b0; S1 = 1'b0; S2 = 1'b0;
        w_data  = '0; w_valid  = 1'b0; w_s1 = 1'b0; w_s2 = 1'b0;

        // Reset held 3 cycles with a valid beat and all consumers ready
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = N'('h55);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", N'(in_ready), N'(0));
        for (int l = 0; l < 4; l++) begin
            check("rst_valid", N'(ov[l]), N'(0));
            check("rst_data", od[l], N'(0));
            check("rst_cnt", N'(oc[l]), N'(0));
        end
        rst_n = 1'b1;
        #1;
        check("first_accept_ready", N'(in_ready), N'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("first_accept_valid", N'(ov[0]), N'(1));
        check("first_accept_data", od[0], N'('h55));

        // Routing: one beat per lane on consecutive cycles
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            send(i, N'(i + 1), w);
            check("route_valid", N'(ov[i]), N'(1));
            check("route_data", od[i], N'(i + 1));
        end
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) check("route_cnt", N'(oc[l]), N'(1));

        // Back-pressure on lane C
        pulse_reset();
        ordy[2] = 1'b0;
        fork
            begin
                send(2, N'('hAA), w);
                send(2, N'('hBB), w);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_stall_ready", N'(in_ready), N'(0));
                check("bp_hold_data", od[2], N'('hAA));
                check("bp_hold_valid", N'(ov[2]), N'(1));
                @(posedge clk);
                #1;
                ordy[2] = 1'b1;
            end
        join
        check("bp_swap_data", od[2], N'('hBB));
        check("bp_swap_valid", N'(ov[2]), N'(1));
        check("bp_cnt1", N'(oc[2]), N'(1));
        @(posedge clk);
        #1;
        check("bp_cnt2", N'(oc[2]), N'(2));
        check("bp_drained", N'(ov[2]), N'(0));

        // Streaming: 100 back-to-back beats to lane B
        pulse_reset();
        for (int i = 0; i < 100; i++) begin
            send(1, N'(i), w);
            if (w != 0) check("stream_stall", N'(w), N'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        check("stream_cnt", N'(oc[1]), N'(100));
        check("stream_last", od[1], N'(99));

        // Reset mid-flight with A and D holding words
        pulse_reset();
        ordy[0] = 1'b0;
        ordy[3] = 1'b0;
        send(0, N'('hA0), w);
        send(3, N'('hD0), w);
        check("mid_hold_a", N'(ov[0]), N'(1));
        check("mid_hold_d", N'(ov[3]), N'(1));
        rst_n    = 1'b0;
        in_valid = 1'b1;
        {S2, S1} = 2'b01;
        in_data  = N'('hB1);
        ordy[0]  = 1'b1;
        ordy[3]  = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int l = 0; l < 4; l++) begin
            check("mid_valid", N'(ov[l]), N'(0));
            check("mid_cnt", N'(oc[l]), N'(0));
        end
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_delivery_a", N'(oc[0]), N'(0));
        check("mid_no_delivery_d", N'(oc[3]), N'(0));

        // Counter wrap on a 4-bit counter: 17 beats to lane D
        pulse_reset();
        wrapped = 1'b0;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    w_valid       = 1'b1;
                    {w_s2, w_s1}  = 2'b11;
                    w_data        = WN'(i);
                    @(negedge clk);
                    check("wrap_ready", N'(w_ready), N'(1));
                    @(posedge clk);
                    #1;
                end
                w_valid = 1'b0;
            end
            begin
                prev = w_oc[3];
                for (int k = 0; k < 22; k++) begin
                    @(negedge clk);
                    cur = w_oc[3];
                    if (prev == 4'd15 && cur == 4'd0) wrapped = 1'b1;
                    check("wrap_step", N'(cur == prev || cur == prev + 4'd1), N'(1));
                    prev = cur;
                end
            end
        join
        check("wrap_seen", N'(wrapped), N'(1));
        check("wrap_final", N'(w_oc[3]), N'(1));
        check("wrap_last_data", N'(w_od[3]), N'(16));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
